// File: rtl/sm83_oam_dma_if.sv
// rtl/sm83_oam_dma_if.sv - sequencer, CPU, memory and OAM signals of the OAM DMA block
interface sm83_oam_dma_if;
   // sequencer phase strobes
   logic        t1;
   logic        t3;
   logic        t4;
   // DMA register access
   logic        reg_wr;
   logic [7:0]  reg_din;
   logic [7:0]  reg_dout;
   // CPU bus arbitration
   logic [15:0] cpu_addr;
   logic        cpu_req;
   logic        cpu_blocked;
   // external bus read side
   logic        dma_active;
   logic        dma_rd;
   logic [15:0] dma_addr;
   logic [7:0]  mem_din;
   // OAM write side
   logic        oam_wr;
   logic [7:0]  oam_addr;
   logic [7:0]  oam_dout;

   // sequencer / CPU / memory side
   modport master (
      output t1, t3, t4, reg_wr, reg_din, cpu_addr, cpu_req, mem_din,
      input  reg_dout, cpu_blocked, dma_active, dma_rd, dma_addr,
             oam_wr, oam_addr, oam_dout
   );

   // DMA controller side
   modport slave (
      input  t1, t3, t4, reg_wr, reg_din, cpu_addr, cpu_req, mem_din,
      output reg_dout, cpu_blocked, dma_active, dma_rd, dma_addr,
             oam_wr, oam_addr, oam_dout
   );
endinterface

// File: rtl/sm83_oam_dma.sv
// rtl/sm83_oam_dma.sv - OAM DMA controller: copies LEN bytes from a source page into OAM
module sm83_oam_dma #(
   parameter int LEN = 160
) (
   input logic             clk,
   input logic             nreset,
   sm83_oam_dma_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2
   } state_t;

   // index of the final byte; 9-bit counter so LEN = 256 still terminates
   localparam logic [8:0] LAST = 9'(LEN - 1);

   state_t      state;
   logic [8:0]  cnt;
   logic [7:0]  page;
   logic [7:0]  oam_data;
   logic        oam_wr_q;
   logic        start_t1;
   logic [7:0]  src_page;
   logic        hram_hit;
   logic        wr_cmd;

   // a register write only counts on the last T-cycle of its M-cycle
   assign wr_cmd = bus.reg_wr & bus.t4;

   // echo RAM pages (E0..FF) fold back onto WRAM so the DMA never reads E000..FFFF
   assign src_page = (page[7:5] == 3'b111) ? (page & 8'hDF) : page;

   // HRAM stays reachable by the CPU while the DMA owns the bus
   assign hram_hit = (bus.cpu_addr >= 16'hFF80) && (bus.cpu_addr <= 16'hFFFE);

   // transfer sequencer: page/counter bookkeeping, byte capture and OAM strobe
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state    <= IDLE;
         cnt      <= '0;
         page     <= '0;
         oam_data <= '0;
         oam_wr_q <= 1'b0;
         start_t1 <= 1'b0;
      end else begin
         // data is latched at the t3 edge and the strobe spans exactly the t4 cycle
         oam_wr_q <= (state == RUN) && bus.t3;
         if ((state == RUN) && bus.t3) begin
            oam_data <= bus.mem_din;
         end
         if (wr_cmd) begin
            // a write from any state (re)starts the transfer from byte 0
            page     <= bus.reg_din;
            state    <= START;
            cnt      <= '0;
            start_t1 <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
               end
               START: begin
                  // only leave START after a full t1..t4 M-cycle has been seen
                  if (bus.t1) begin
                     start_t1 <= 1'b1;
                  end
                  if (bus.t4 && start_t1) begin
                     state <= RUN;
                  end
               end
               RUN: begin
                  if (bus.t4) begin
                     cnt <= cnt + 9'd1;
                     if (cnt == LAST) begin
                        state <= IDLE;
                     end
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   // outputs decoded from registered state only, except the CPU block path
   assign bus.reg_dout    = page;
   assign bus.dma_active  = (state != IDLE);
   assign bus.dma_rd      = (state == RUN);
   assign bus.dma_addr    = {src_page, cnt[7:0]};
   assign bus.oam_wr      = oam_wr_q;
   assign bus.oam_addr    = cnt[7:0];
   assign bus.oam_dout    = oam_data;
   assign bus.cpu_blocked = (state == RUN) & bus.cpu_req & ~hram_hit;

endmodule

// File: tb/tb_sm83_oam_dma.sv
// tb/tb_sm83_oam_dma.sv - directed bench for sm83_oam_dma (LEN 160 and LEN 256 instances)
module tb_sm83_oam_dma;

   logic clk;
   logic nreset;

   sm83_oam_dma_if b1 ();
   sm83_oam_dma_if b2 ();

   sm83_oam_dma #(.LEN(160)) dut1 (.clk(clk), .nreset(nreset), .bus(b1.slave));
   sm83_oam_dma #(.LEN(256)) dut2 (.clk(clk), .nreset(nreset), .bus(b2.slave));

   typedef struct {
      logic [15:0] addr;
      logic        req;
      logic        blk_run;
      logic        blk_start;
   } arb_vec_t;

   arb_vec_t arb_tab [9];

   int n_tests = 0;
   int n_fail  = 0;
   bit do_arb  = 0;

   logic        s_act, s_rd, s_wr;
   logic [15:0] s_addr;
   logic [7:0]  s_oa, s_od;

   initial clk = 1'b0;
   always #10 clk = ~clk;

   function automatic logic [7:0] mem_byte(input logic [15:0] a);
      return a[15:8] ^ {a[6:0], a[7]} ^ 8'h3C;
   endfunction

   assign b1.mem_din = mem_byte(b1.dma_addr);
   assign b2.mem_din = mem_byte(b2.dma_addr);

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s idx=%0d actual=%h required=%h", name, idx, act, exp);
      end
   endtask

   // one clk cycle of phase p; returns at the negedge with outputs sampled
   task automatic cyc(input int sel, input int p, input logic wr, input logic [7:0] din);
      @(posedge clk);
      #1;
      b1.t1 = (p == 1); b1.t3 = (p == 3); b1.t4 = (p == 4);
      b2.t1 = (p == 1); b2.t3 = (p == 3); b2.t4 = (p == 4);
      b1.reg_wr = (sel == 0) && wr;
      b2.reg_wr = (sel == 1) && wr;
      b1.reg_din = din;
      b2.reg_din = din;
      @(negedge clk);
      if (sel == 0) begin
         s_act = b1.dma_active; s_rd = b1.dma_rd; s_addr = b1.dma_addr;
         s_wr = b1.oam_wr; s_oa = b1.oam_addr; s_od = b1.oam_dout;
      end else begin
         s_act = b2.dma_active; s_rd = b2.dma_rd; s_addr = b2.dma_addr;
         s_wr = b2.oam_wr; s_oa = b2.oam_addr; s_od = b2.oam_dout;
      end
   endtask

   task automatic arb_apply(input bit in_run);
      for (int i = 0; i < 9; i++) begin
         b1.cpu_addr = arb_tab[i].addr;
         b1.cpu_req  = arb_tab[i].req;
         #1;
         chk(in_run ? "blk_run" : "blk_start", i, 32'(b1.cpu_blocked),
             32'(in_run ? arb_tab[i].blk_run : arb_tab[i].blk_start));
      end
      b1.cpu_req  = 1'b0;
      b1.cpu_addr = 16'h0000;
   endtask

   task automatic write_page(input int sel, input logic [7:0] din);
      cyc(sel, 1, 1'b0, 8'h00);
      cyc(sel, 2, 1'b0, 8'h00);
      cyc(sel, 3, 1'b0, 8'h00);
      cyc(sel, 4, 1'b1, din);
   endtask

   task automatic start_cycle(input int sel);
      for (int p = 1; p <= 4; p++) begin
         cyc(sel, p, 1'b0, 8'h00);
         chk("start_active", p, 32'(s_act), 32'd1);
         chk("start_rd", p, 32'(s_rd), 32'd0);
         chk("start_oam_wr", p, 32'(s_wr), 32'd0);
         if (do_arb && p == 2) arb_apply(1'b0);
      end
   endtask

   task automatic run_bytes(input int sel, input logic [7:0] src, input int kfrom, input int kto,
                            input logic wr_last, input logic [7:0] din);
      logic [15:0] ea;
      for (int k = kfrom; k < kto; k++) begin
         ea = {src, 8'(k)};
         for (int p = 1; p <= 4; p++) begin
            cyc(sel, p, wr_last && (k == kto - 1) && (p == 4), din);
            chk("run_active", k, 32'(s_act), 32'd1);
            chk("run_rd", k, 32'(s_rd), 32'd1);
            chk("dma_addr", k, 32'(s_addr), 32'(ea));
            chk("oam_wr", k, 32'(s_wr), 32'(p == 4));
            if (p == 4) begin
               chk("oam_addr", k, 32'(s_oa), 32'(k[7:0]));
               chk("oam_dout", k, 32'(s_od), 32'(mem_byte(ea)));
            end
            if (do_arb && k == kfrom && p == 2) arb_apply(1'b1);
         end
      end
   endtask

   task automatic expect_idle(input int sel);
      for (int p = 1; p <= 4; p++) begin
         cyc(sel, p, 1'b0, 8'h00);
         chk("idle_active", p, 32'(s_act), 32'd0);
         chk("idle_rd", p, 32'(s_rd), 32'd0);
         chk("idle_oam_wr", p, 32'(s_wr), 32'd0);
      end
   endtask

   task automatic zero_check(input int tag);
      chk("rst_reg_dout", tag, 32'(b1.reg_dout), 32'd0);
      chk("rst_active", tag, 32'(b1.dma_active), 32'd0);
      chk("rst_rd", tag, 32'(b1.dma_rd), 32'd0);
      chk("rst_oam_wr", tag, 32'(b1.oam_wr), 32'd0);
      chk("rst_dma_addr", tag, 32'(b1.dma_addr), 32'd0);
      chk("rst_oam_addr", tag, 32'(b1.oam_addr), 32'd0);
      chk("rst_oam_dout", tag, 32'(b1.oam_dout), 32'd0);
      chk("rst_blocked", tag, 32'(b1.cpu_blocked), 32'd0);
   endtask

   initial begin
      arb_tab[0] = '{16'hC000, 1'b1, 1'b1, 1'b0};
      arb_tab[1] = '{16'hFF40, 1'b1, 1'b1, 1'b0};
      arb_tab[2] = '{16'hFFFF, 1'b1, 1'b1, 1'b0};
      arb_tab[3] = '{16'hFF90, 1'b1, 1'b0, 1'b0};
      arb_tab[4] = '{16'hFF80, 1'b1, 1'b0, 1'b0};
      arb_tab[5] = '{16'hFFFE, 1'b1, 1'b0, 1'b0};
      arb_tab[6] = '{16'hFF7F, 1'b1, 1'b1, 1'b0};
      arb_tab[7] = '{16'h8000, 1'b1, 1'b1, 1'b0};
      arb_tab[8] = '{16'hC000, 1'b0, 1'b0, 1'b0};

      nreset = 1'b0;
      b1.t1 = 0; b1.t3 = 0; b1.t4 = 0; b1.reg_wr = 0; b1.reg_din = 0;
      b2.t1 = 0; b2.t3 = 0; b2.t4 = 0; b2.reg_wr = 0; b2.reg_din = 0;
      b1.cpu_addr = 16'hC000; b1.cpu_req = 1'b1;
      b2.cpu_addr = 16'h0000; b2.cpu_req = 1'b0;
      #3;
      zero_check(0);
      b1.cpu_req = 1'b0;
      #2 nreset = 1'b1;

      // a register write outside t4 is ignored
      cyc(0, 1, 1'b0, 8'h00);
      cyc(0, 2, 1'b1, 8'h55);
      cyc(0, 3, 1'b0, 8'h00);
      chk("ign_active", 0, 32'(s_act), 32'd0);
      chk("ign_reg_dout", 0, 32'(b1.reg_dout), 32'd0);
      cyc(0, 4, 1'b0, 8'h00);

      // plain transfer from page C1
      write_page(0, 8'hC1);
      start_cycle(0);
      run_bytes(0, 8'hC1, 0, 160, 1'b0, 8'h00);
      expect_idle(0);
      chk("reg_dout_c1", 0, 32'(b1.reg_dout), 32'hC1);

      // echo page FE folds to DE, with arbitration table in START and RUN
      do_arb = 1;
      write_page(0, 8'hFE);
      start_cycle(0);
      run_bytes(0, 8'hDE, 0, 160, 1'b0, 8'h00);
      do_arb = 0;
      expect_idle(0);
      chk("reg_dout_fe", 0, 32'(b1.reg_dout), 32'hFE);

      // restart at byte 50: byte 50 still lands, then START and page 80 from byte 0
      write_page(0, 8'h12);
      start_cycle(0);
      run_bytes(0, 8'h12, 0, 51, 1'b1, 8'h80);
      start_cycle(0);
      chk("restart_reg_dout", 0, 32'(b1.reg_dout), 32'h80);
      run_bytes(0, 8'h80, 0, 160, 1'b0, 8'h00);
      expect_idle(0);

      // asynchronous reset mid-t2 of byte 10
      write_page(0, 8'h34);
      start_cycle(0);
      run_bytes(0, 8'h34, 0, 10, 1'b0, 8'h00);
      b1.cpu_addr = 16'hC000; b1.cpu_req = 1'b1;
      cyc(0, 1, 1'b0, 8'h00);
      cyc(0, 2, 1'b0, 8'h00);
      chk("pre_rst_blocked", 0, 32'(b1.cpu_blocked), 32'd1);
      #1 nreset = 1'b0;
      #1;
      zero_check(1);
      cyc(0, 3, 1'b0, 8'h00);
      cyc(0, 4, 1'b0, 8'h00);
      zero_check(2);
      #1 nreset = 1'b1;
      b1.cpu_req = 1'b0;
      for (int m = 0; m < 3; m++) expect_idle(0);

      // LEN = 256 instance: full page, no wrap into a 257th write
      write_page(1, 8'h47);
      start_cycle(1);
      run_bytes(1, 8'h47, 0, 256, 1'b0, 8'h00);
      expect_idle(1);
      expect_idle(1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sm83_oam_dma.md
# sm83_oam_dma

OAM DMA controller for the SM83 core. On a write to the DMA source-page register it copies 160 bytes from `{page, 8'h00}` into OAM, one byte per machine cycle, paced by the sequencer's T-phase strobes. While copying it owns the external memory bus, and it blocks CPU accesses everywhere except HRAM. It sits between the SM83 sequencer/bus interface and the memory/OAM decoders.

## Interface
Parameters:
- LEN, default 160: number of bytes per transfer (1..256).

Ports:
- clk  in  1  core clock, same clock as the sequencer.
- nreset  in  1  asynchronous, active-low reset.
- t1  in  1  sequencer phase strobe: first T-cycle of the M-cycle.
- t3  in  1  sequencer phase strobe: third T-cycle of the M-cycle.
- t4  in  1  sequencer phase strobe: last T-cycle of the M-cycle.
- reg_wr  in  1  CPU write to the DMA register. Valid only in a t4 cycle.
- reg_din  in  8  source page written by the CPU.
- reg_dout  out  8  last written source page (register readback).
- cpu_addr  in  16  CPU bus address.
- cpu_req  in  1  CPU read or write request this M-cycle.
- cpu_blocked  out  1  CPU access suppressed: writes are dropped and reads return 8'hFF downstream.
- dma_active  out  1  transfer in progress, START or RUN.
- dma_rd  out  1  DMA owns the external bus and reads it.
- dma_addr  out  16  DMA source address.
- mem_din  in  8  external bus read data.
- oam_wr  out  1  OAM write strobe.
- oam_addr  out  8  OAM byte index.
- oam_dout  out  8  OAM write data.

## Operation
- States: IDLE, START, RUN.
- reg_wr at a t4 edge:
  - reg_dout and page are set to reg_din.
  - The state goes to START and the byte counter is cleared to 0.
  - This applies from any state.
- START lasts exactly one full M-cycle (t1..t4). At its t4 edge the state goes to RUN.
- RUN M-cycle k, for k = 0..LEN-1:
  - dma_rd = 1 for the whole M-cycle.
  - dma_addr = {src_page, k[7:0]}.
  - mem_din is captured into oam_dout at the t3 edge.
  - oam_wr = 1 during t4 only, with oam_addr = k.
  - At the t4 edge the counter increments.
- After byte LEN-1, the t4 edge returns the state to IDLE.
- src_page = page, except that pages 8'hE0..8'hFF map to page & 8'hDF (echo RAM to WRAM). dma_addr never falls in 16'hE000..16'hFFFF.
- Restart: reg_wr during RUN or START aborts the current transfer at that t4 edge.
  - The current M-cycle's OAM write still completes, because it occurs in that same t4 cycle.
  - START follows, then the transfer restarts from byte 0 with the new page.
  - dma_active stays 1 with no gap.
- Arbitration:
  - cpu_blocked = dma_rd & cpu_req & !(cpu_addr in 16'hFF80..16'hFFFE).
  - In START the CPU keeps the bus: cpu_blocked = 0, dma_rd = 0.
  - IE (16'hFFFF) and I/O (16'hFF00..16'hFF7F) accesses are also blocked.
- dma_active = (state != IDLE).
- Arithmetic:
  - The counter is 9 bits, so LEN = 256 terminates correctly.
  - oam_addr and dma_addr[7:0] use counter[7:0].
- Reset (nreset low, asynchronous), all outputs and state cleared:
  - state = IDLE, counter = 0, page = 0, reg_dout = 0.
  - dma_active = 0, dma_rd = 0, oam_wr = 0.
  - dma_addr = 0, oam_addr = 0, oam_dout = 0, cpu_blocked = 0.
- Reset mid-transfer abandons it immediately. No further oam_wr is issued after nreset deasserts until a new reg_wr.

## Timing
- All state changes occur on posedge clk, qualified by the phase strobes. Strobes are one-hot and each lasts one clk.
- Latency:
  - reg_wr in the t4 of M-cycle N gives START in M-cycle N+1.
  - First dma_rd in M-cycle N+2.
  - Last oam_wr in the t4 of M-cycle N+1+LEN.
  - dma_active falls at the following edge.
- oam_dout is stable from the t3 edge through t4, so OAM samples it at the t4 edge with oam_wr high.
- Outputs are registered or decoded only from state and counter. The only combinational path from inputs is cpu_req/cpu_addr to cpu_blocked.
- reg_wr outside t4 is ignored. The strobe inputs hold the ordering t1,t2,t3,t4 (t2 is unused).

## Test plan
- Reset, then write 8'hC1 at a t4 → START for 1 M-cycle. Then 160 M-cycles with dma_addr C100..C19F. oam_wr asserted only in t4, oam_addr 0..159, oam_dout = mem model bytes. dma_active = 0 afterwards.
- Write 8'hFE → dma_addr DE00..DE9F, never FExx. reg_dout reads back 8'hFE.
- During RUN: CPU read at 16'hFF90 → cpu_blocked = 0. Reads at 16'hC000, 16'hFF40 and 16'hFFFF → cpu_blocked = 1. During START the same accesses → cpu_blocked = 0.
- Rewrite 8'h80 at byte 50 → byte 50 is still written to OAM. Next M-cycle is START with dma_rd = 0. Transfer restarts at 16'h8000, oam_addr 0. dma_active is never 0 in between.
- Pull nreset low asynchronously mid-t2 at byte 10 → every output reads 0 in the same cycle. No oam_wr appears after release.
- LEN = 256 build → 256 transfers with oam_addr 0..255. The state returns to IDLE; the counter does not wrap into a 257th write.
